// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 core: board size defaults,
// player and winner encodings, and the move controller state set.
package connect4_pkg;

  localparam int COLS_DEF = 7;
  localparam int ROWS_DEF = 6;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    CHECK,
    OVER
  } mc_state_e;

  function automatic logic [1:0] winner_code(input player_t p);
    return (p == P2) ? WIN_P2 : WIN_P1;
  endfunction

endpackage

// File: rtl/move_controller_column_heights.sv
// Per-column fill counters: clear all, increment the indexed column, and
// report the indexed column's height and whether it is full.
module column_heights
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic [$clog2(COLS)-1:0]    idx_i,
  output logic [$clog2(ROWS+1)-1:0]  height_o,
  output logic                       full_o
);

  localparam int CW = $clog2(COLS);
  localparam int HW = $clog2(ROWS+1);

  logic [HW-1:0] heights_q [COLS];

  always_comb begin
    height_o = '0;
    for (int c = 0; c < COLS; c++) begin
      if (idx_i == CW'(c)) height_o = heights_q[c];
    end
  end

  assign full_o = (height_o == HW'(ROWS));

  // A full column is never bumped, so heights saturate at ROWS.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int c = 0; c < COLS; c++) heights_q[c] <= '0;
    end else if (inc_i && !full_o) begin
      for (int c = 0; c < COLS; c++) begin
        if (idx_i == CW'(c)) heights_q[c] <= heights_q[c] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// Connect-4 move controller: turns debounced left/right/put pulses into cursor
// moves and board writes, then hands each write to the win checker.
module move_controller
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     left_pulse_i,
  input  logic                     right_pulse_i,
  input  logic                     put_pulse_i,
  input  logic                     check_ack_i,
  input  logic                     win_i,
  output logic [$clog2(COLS)-1:0]  cursor_col_o,
  output logic                     player_o,
  output logic                     wr_en_o,
  output logic [$clog2(ROWS)-1:0]  wr_row_o,
  output logic [$clog2(COLS)-1:0]  wr_col_o,
  output logic                     wr_player_o,
  output logic                     check_req_o,
  output logic                     col_full_o,
  output logic                     clr_board_o,
  output logic                     game_over_o,
  output logic [1:0]               winner_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS+1);
  localparam int MW = $clog2(COLS*ROWS+1);

  mc_state_e     state_q, state_d;
  logic [CW-1:0] cursor_q, cursor_d;
  player_t       player_q, player_d;
  logic [1:0]    winner_q, winner_d;
  logic [MW-1:0] move_cnt_q, move_cnt_d;
  logic          clr_q, clr_d;

  logic [HW-1:0] height;
  logic          col_full;

  column_heights #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_heights (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_d),
    .inc_i    (wr_en_o),
    .idx_i    (cursor_q),
    .height_o (height),
    .full_o   (col_full)
  );

  // move_cnt is already bumped by the time CHECK sees the ack, so the
  // draw test compares against the full board count directly.
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    player_d   = player_q;
    winner_d   = winner_q;
    move_cnt_d = move_cnt_q;
    clr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (left_pulse_i) begin
          cursor_d = (cursor_q == '0) ? CW'(COLS-1) : cursor_q - 1'b1;
        end else if (right_pulse_i) begin
          cursor_d = (cursor_q == CW'(COLS-1)) ? '0 : cursor_q + 1'b1;
        end else if (put_pulse_i && !col_full) begin
          state_d = DROP;
        end
      end
      DROP: begin
        move_cnt_d = move_cnt_q + 1'b1;
        state_d    = CHECK;
      end
      CHECK: begin
        if (check_ack_i) begin
          if (win_i) begin
            state_d  = OVER;
            winner_d = winner_code(player_q);
          end else if (move_cnt_q == MW'(COLS*ROWS)) begin
            state_d  = OVER;
            winner_d = WIN_DRAW;
          end else begin
            player_d = (player_q == P1) ? P2 : P1;
            state_d  = IDLE;
          end
        end
      end
      OVER: begin
        if (put_pulse_i) begin
          clr_d      = 1'b1;
          state_d    = IDLE;
          cursor_d   = '0;
          player_d   = P1;
          winner_d   = WIN_NONE;
          move_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      player_q   <= P1;
      winner_q   <= WIN_NONE;
      move_cnt_q <= '0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      move_cnt_q <= move_cnt_d;
      clr_q      <= clr_d;
    end
  end

  // A legal drop never sees height == ROWS, so the low RW bits are the row.
  assign wr_en_o      = (state_q == DROP);
  assign wr_row_o     = wr_en_o ? height[RW-1:0] : '0;
  assign wr_col_o     = wr_en_o ? cursor_q : '0;
  assign wr_player_o  = wr_en_o ? player_q : 1'b0;
  assign check_req_o  = (state_q == CHECK);
  assign game_over_o  = (state_q == OVER);
  assign clr_board_o  = clr_q;
  assign col_full_o   = col_full;
  assign cursor_col_o = cursor_q;
  assign player_o     = player_q;
  assign winner_o     = winner_q;

endmodule
